// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read hits return data combinationally; read misses fill a whole 4-word line;
// every store is forwarded to memory as a single-word write.
// Handshake: cpu_read/cpu_write are held until stall=0, and that cycle is the
// completion cycle. mem_read/mem_write are held until a one-cycle mem_ready
// pulse (fill data valid or write accepted) and are never high together.
module dcache_direct_mapped #(
    parameter int NUM_LINES = 4,
    parameter int WORD      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [WORD-1:0]   cpu_addr,
    input  logic [WORD-1:0]   cpu_wdata,
    output logic [WORD-1:0]   cpu_rdata,
    output logic              stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [WORD-1:0]   mem_addr,
    output logic [WORD-1:0]   mem_wdata,
    input  logic [4*WORD-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count,
    output logic [1:0]        dbgState
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = WORD - IW - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } cacheState_e;

    cacheState_e state;
    cacheState_e nextState;

    // Line storage; only the valid bits are reset.
    logic [NUM_LINES-1:0]   validBits;
    logic [TW-1:0]          tagMem  [NUM_LINES];
    logic [3:0][WORD-1:0]   lineMem [NUM_LINES];

    logic [IW-1:0] reqIdx;
    logic [TW-1:0] reqTag;
    logic [1:0]    reqOff;
    logic [IW-1:0] fillIdx;
    logic [TW-1:0] fillTag;
    logic          hit;

    // Set on write completion so the held store retires without reissuing.
    logic          done;
    // Remembers whether the outstanding store hit, for the completion count.
    logic          writeHitQ;

    logic hitInc;
    logic missInc;
    logic startFill;
    logic startWrite;
    logic fillDone;
    logic writeDone;

    assign reqIdx   = cpu_addr[IW+1:2];
    assign reqTag   = cpu_addr[WORD-1:IW+2];
    assign reqOff   = cpu_addr[1:0];
    // Fill target comes from the registered line address, not the live CPU bus.
    assign fillIdx  = mem_addr[IW+1:2];
    assign fillTag  = mem_addr[WORD-1:IW+2];
    assign hit      = validBits[reqIdx] && (tagMem[reqIdx] == reqTag);
    assign dbgState = state;

    // Next-state, stall and read-data decode.
    always_comb begin
        nextState  = state;
        stall      = 1'b0;
        cpu_rdata  = '0;
        hitInc     = 1'b0;
        missInc    = 1'b0;
        startFill  = 1'b0;
        startWrite = 1'b0;
        fillDone   = 1'b0;
        writeDone  = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_write) begin
                    if (!done) begin
                        stall      = 1'b1;
                        startWrite = 1'b1;
                        nextState  = WRITE;
                    end
                end else if (cpu_read) begin
                    if (hit) begin
                        cpu_rdata = lineMem[reqIdx][reqOff];
                        hitInc    = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        startFill = 1'b1;
                        missInc   = 1'b1;
                        nextState = FILL;
                    end
                end
            end
            FILL: begin
                stall = 1'b1;
                if (mem_ready) begin
                    fillDone  = 1'b1;
                    nextState = IDLE;
                end
            end
            WRITE: begin
                stall = 1'b1;
                if (mem_ready) begin
                    writeDone = 1'b1;
                    hitInc    = writeHitQ;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Control state, memory request registers and saturating counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            validBits  <= '0;
            done       <= 1'b0;
            writeHitQ  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= nextState;
            if (writeDone) begin
                done <= 1'b1;
            end else if (state == IDLE) begin
                done <= 1'b0;
            end
            if (startFill) begin
                mem_read <= 1'b1;
                mem_addr <= {cpu_addr[WORD-1:2], 2'b00};
            end
            if (startWrite) begin
                mem_write <= 1'b1;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
                writeHitQ <= hit;
            end
            if (fillDone) begin
                validBits[fillIdx] <= 1'b1;
                mem_read           <= 1'b0;
                mem_addr           <= '0;
            end
            if (writeDone) begin
                mem_write <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
            end
            if (hitInc && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (missInc && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

    // Tag and data arrays: line fill on fill completion, word update on store hit.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (startWrite && hit) begin
                lineMem[reqIdx][reqOff] <= cpu_wdata;
            end
            if (fillDone) begin
                lineMem[fillIdx] <= mem_rdata;
                tagMem[fillIdx]  <= fillTag;
            end
        end
    end

endmodule
